// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-through bypass, immediate extender,
// RAW-hazard scoreboard with selectable forwarding mode, and the decode->execute register.
module decode_issue_stage #(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 32,
    parameter int DEPTH     = 3,
    parameter int FORWARD   = 1,
    parameter int PAYLOAD_W = 16,
    parameter int STALL_W   = 16,
    localparam int REG_W    = $clog2(NREGS)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_W-1:0]     in_rs,
    input  logic [REG_W-1:0]     in_rt,
    input  logic                 in_use_rs,
    input  logic                 in_use_rt,
    input  logic [REG_W-1:0]     in_wsel,
    input  logic                 in_regwen,
    input  logic                 in_is_load,
    input  logic [15:0]          in_imm,
    input  logic [1:0]           in_imm_mode,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 out_ready,
    input  logic                 flush,
    input  logic                 wb_wen,
    input  logic [REG_W-1:0]     wb_wsel,
    input  logic [DATA_W-1:0]    wb_wdat,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_rdat1,
    output logic [DATA_W-1:0]    out_rdat2,
    output logic [DATA_W-1:0]    out_imm,
    output logic [REG_W-1:0]     out_wsel,
    output logic                 out_regwen,
    output logic                 out_is_load,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [STALL_W-1:0]   stall_cnt
);

    logic [DATA_W-1:0]    rf_q [NREGS];
    logic [DEPTH-1:0]     sb_valid_q;
    logic [DEPTH-1:0]     sb_regwen_q;
    logic [DEPTH-1:0]     sb_load_q;
    logic [REG_W-1:0]     sb_wsel_q [DEPTH];
    logic [DATA_W-1:0]    rdat1_q, rdat2_q, imm_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [STALL_W-1:0]   stall_q;

    logic [DATA_W-1:0]    rdat1_d, rdat2_d, imm_d;
    logic [DEPTH-1:0]     match_s;
    logic                 hazard_s;
    logic                 issue_s;

    // Register file write port; r0 is never written.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_wen && (wb_wsel != '0)) begin
            rf_q[wb_wsel] <= wb_wdat;
        end
    end

    // Operand read with same-cycle writeback bypass.
    always_comb begin
        rdat1_d = (in_rs == '0) ? '0 :
                  (wb_wen && (wb_wsel == in_rs)) ? wb_wdat : rf_q[in_rs];
        rdat2_d = (in_rt == '0) ? '0 :
                  (wb_wen && (wb_wsel == in_rt)) ? wb_wdat : rf_q[in_rt];
    end

    // Immediate extension; the reserved mode behaves as zero-extend.
    always_comb begin
        case (in_imm_mode)
            2'd0:    imm_d = {{(DATA_W-16){1'b0}}, in_imm};
            2'd1:    imm_d = {{(DATA_W-16){in_imm[15]}}, in_imm};
            2'd2:    imm_d = {{(DATA_W-16){1'b0}}, in_imm} << 5'd16;
            default: imm_d = {{(DATA_W-16){1'b0}}, in_imm};
        endcase
    end

    // With forwarding only a load sitting in entry 0 can block; without it any pending write does.
    always_comb begin
        match_s  = '0;
        hazard_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = sb_valid_q[k] & sb_regwen_q[k] & (sb_wsel_q[k] != '0) &
                         ((in_use_rs & (in_rs == sb_wsel_q[k])) |
                          (in_use_rt & (in_rt == sb_wsel_q[k])));
            hazard_s   = hazard_s | (match_s[k] & ((FORWARD == 0) | ((k == 0) & sb_load_q[k])));
        end
    end

    assign in_ready = out_ready & ~hazard_s;
    assign issue_s  = in_valid & in_ready;

    // Output register doubles as scoreboard entry 0; flush overrides the load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sb_valid_q  <= '0;
            sb_regwen_q <= '0;
            sb_load_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                sb_wsel_q[k] <= '0;
            end
            rdat1_q   <= '0;
            rdat2_q   <= '0;
            imm_q     <= '0;
            payload_q <= '0;
        end else begin
            if (out_ready) begin
                for (int k = 1; k < DEPTH; k++) begin
                    sb_valid_q[k]  <= sb_valid_q[k-1];
                    sb_regwen_q[k] <= sb_regwen_q[k-1];
                    sb_load_q[k]   <= sb_load_q[k-1];
                    sb_wsel_q[k]   <= sb_wsel_q[k-1];
                end
                sb_valid_q[0]  <= issue_s;
                sb_regwen_q[0] <= in_regwen;
                sb_load_q[0]   <= in_is_load;
                sb_wsel_q[0]   <= in_wsel;
                rdat1_q        <= rdat1_d;
                rdat2_q        <= rdat2_d;
                imm_q          <= imm_d;
                payload_q      <= in_payload;
            end
            if (flush) begin
                sb_valid_q[0] <= 1'b0;
            end
        end
    end

    // Saturating count of cycles lost to hazards.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
        end else if (in_valid && out_ready && hazard_s && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1'b1);
        end
    end

    assign out_valid   = sb_valid_q[0];
    assign out_regwen  = sb_regwen_q[0];
    assign out_is_load = sb_load_q[0];
    assign out_wsel    = sb_wsel_q[0];
    assign out_rdat1   = rdat1_q;
    assign out_rdat2   = rdat2_q;
    assign out_imm     = imm_q;
    assign out_payload = payload_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: a forwarding instance drives a scoreboard queue,
// two non-forwarding instances cover the pending-write stall and counter saturation.
module tb_decode_issue_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in_valid, in_use_rs, in_use_rt, in_regwen, in_is_load;
    logic [4:0]  in_rs, in_rt, in_wsel, wb_wsel;
    logic [15:0] in_imm, in_payload;
    logic [1:0]  in_imm_mode;
    logic        out_ready, flush, wb_wen;
    logic [31:0] wb_wdat;

    logic        o1_ready, o1_valid, o1_rw, o1_ld;
    logic [31:0] o1_r1, o1_r2, o1_imm;
    logic [4:0]  o1_wsel;
    logic [15:0] o1_pl;
    logic [1:0]  o1_stall;

    logic        o0_ready, o0_valid, o0_rw, o0_ld;
    logic [31:0] o0_r1, o0_r2, o0_imm;
    logic [4:0]  o0_wsel;
    logic [15:0] o0_pl;
    logic [15:0] o0_stall;

    logic        o2_ready, o2_valid, o2_rw, o2_ld;
    logic [31:0] o2_r1, o2_r2, o2_imm;
    logic [4:0]  o2_wsel;
    logic [15:0] o2_pl;
    logic [1:0]  o2_stall;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] imm;
        logic [4:0]  ws;
        logic [15:0] pl;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic sb_en;

    always #5 CLK = ~CLK;

    decode_issue_stage #(.FORWARD(1), .DEPTH(3), .STALL_W(2)) dut1 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(o1_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_wsel(in_wsel), .in_regwen(in_regwen), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_imm_mode(in_imm_mode), .in_payload(in_payload),
        .out_ready(out_ready), .flush(flush), .wb_wen(wb_wen), .wb_wsel(wb_wsel),
        .wb_wdat(wb_wdat), .out_valid(o1_valid), .out_rdat1(o1_r1), .out_rdat2(o1_r2),
        .out_imm(o1_imm), .out_wsel(o1_wsel), .out_regwen(o1_rw), .out_is_load(o1_ld),
        .out_payload(o1_pl), .stall_cnt(o1_stall)
    );

    decode_issue_stage #(.FORWARD(0), .DEPTH(3), .STALL_W(16)) dut0 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(o0_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_wsel(in_wsel), .in_regwen(in_regwen), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_imm_mode(in_imm_mode), .in_payload(in_payload),
        .out_ready(out_ready), .flush(flush), .wb_wen(wb_wen), .wb_wsel(wb_wsel),
        .wb_wdat(wb_wdat), .out_valid(o0_valid), .out_rdat1(o0_r1), .out_rdat2(o0_r2),
        .out_imm(o0_imm), .out_wsel(o0_wsel), .out_regwen(o0_rw), .out_is_load(o0_ld),
        .out_payload(o0_pl), .stall_cnt(o0_stall)
    );

    decode_issue_stage #(.FORWARD(0), .DEPTH(3), .STALL_W(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(o2_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_wsel(in_wsel), .in_regwen(in_regwen), .in_is_load(in_is_load),
        .in_imm(in_imm), .in_imm_mode(in_imm_mode), .in_payload(in_payload),
        .out_ready(out_ready), .flush(flush), .wb_wen(wb_wen), .wb_wsel(wb_wsel),
        .wb_wdat(wb_wdat), .out_valid(o2_valid), .out_rdat1(o2_r1), .out_rdat2(o2_r2),
        .out_imm(o2_imm), .out_wsel(o2_wsel), .out_regwen(o2_rw), .out_is_load(o2_ld),
        .out_payload(o2_pl), .stall_cnt(o2_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; pops the scoreboard when the forwarding instance loads a live instruction.
    task automatic tick();
        logic acc;
        exp_t e;
        acc = out_ready;
        @(posedge CLK);
        #1;
        if (sb_en && acc && o1_valid) begin
            if (sbq.size() == 0) begin
                check("sb_spurious_valid", {63'd0, o1_valid}, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_rdat1", {32'd0, o1_r1}, {32'd0, e.r1});
                check("sb_rdat2", {32'd0, o1_r2}, {32'd0, e.r2});
                check("sb_imm", {32'd0, o1_imm}, {32'd0, e.imm});
                check("sb_wsel", {59'd0, o1_wsel}, {59'd0, e.ws});
                check("sb_payload", {48'd0, o1_pl}, {48'd0, e.pl});
            end
        end
    endtask

    task automatic send(input int which, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] ws,
                        input logic rw, input logic ld, input logic [1:0] mode,
                        input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ei,
                        input int stalls);
        in_rs = rs; in_rt = rt; in_use_rs = urs; in_use_rt = urt;
        in_wsel = ws; in_regwen = rw; in_is_load = ld; in_imm_mode = mode;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < stalls; i++) begin
            check("stall_ready", {63'd0, (which == 0) ? o0_ready : o1_ready}, 64'd0);
            tick();
        end
        check("issue_ready", {63'd0, (which == 0) ? o0_ready : o1_ready}, 64'd1);
        if (which == 1) sbq.push_back(exp_t'{e1, e2, ei, ws, in_payload});
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; in_valid = 1'b0; in_use_rs = 1'b0; in_use_rt = 1'b0;
        in_regwen = 1'b0; in_is_load = 1'b0; in_rs = 5'd0; in_rt = 5'd0; in_wsel = 5'd0;
        in_imm = 16'h8001; in_imm_mode = 2'd0; in_payload = 16'hA5A5;
        out_ready = 1'b1; flush = 1'b0; wb_wen = 1'b0; wb_wsel = 5'd0; wb_wdat = 32'd0;
        sb_en = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_valid", {63'd0, o1_valid}, 64'd0);
        check("rst_rdat1", {32'd0, o1_r1}, 64'd0);
        check("rst_imm", {32'd0, o1_imm}, 64'd0);
        check("rst_payload", {48'd0, o1_pl}, 64'd0);
        check("rst_stall1", {62'd0, o1_stall}, 64'd0);
        check("rst_stall0", {48'd0, o0_stall}, 64'd0);
        nRST = 1'b1;

        // Writeback then read, same-cycle bypass, r0 semantics, immediate modes.
        wb_wen = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'h0000_1234;
        tick();
        wb_wen = 1'b0;
        send(1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 2'd0, 32'h1234, 32'h0, 32'h0000_8001, 0);
        check("valid_after_issue", {63'd0, o1_valid}, 64'd1);
        wb_wen = 1'b1; wb_wsel = 5'd7; wb_wdat = 32'h0000_CAFE; in_payload = 16'h5A5A;
        send(1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 2'd1, 32'h1234, 32'hCAFE, 32'hFFFF_8001, 0);
        wb_wsel = 5'd0; wb_wdat = 32'h0000_DEAD;
        send(1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 32'h8001_0000, 0);
        wb_wen = 1'b0;
        send(1, 5'd0, 5'd7, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 2'd3, 32'h0, 32'hCAFE, 32'h0000_8001, 0);

        // Load-use costs one stall; an ALU producer costs none.
        send(1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 2'd0, 32'h1234, 32'h0, 32'h8001, 0);
        send(1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 2'd0, 32'h0, 32'h1234, 32'h8001, 1);
        check("stall_loaduse", {62'd0, o1_stall}, 64'd1);
        send(1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 2'd0, 32'h1234, 32'h0, 32'h8001, 0);
        send(1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h8001, 0);
        check("stall_alu", {62'd0, o1_stall}, 64'd1);

        // Freeze behind a load with a dependent waiting, then flush it away.
        send(1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b1, 2'd0, 32'h1234, 32'h0, 32'h8001, 0);
        out_ready = 1'b0; in_rs = 5'd10; in_use_rs = 1'b1; in_rt = 5'd5; in_use_rt = 1'b1;
        in_wsel = 5'd14; in_regwen = 1'b1; in_is_load = 1'b0; in_valid = 1'b1;
        wb_wen = 1'b1; wb_wsel = 5'd5; wb_wdat = 32'h0000_5555;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("frz_ready", {63'd0, o1_ready}, 64'd0);
            check("frz_valid", {63'd0, o1_valid}, 64'd1);
            check("frz_rdat1", {32'd0, o1_r1}, 64'h1234);
            check("frz_stall", {62'd0, o1_stall}, 64'd1);
            tick();
            wb_wen = 1'b0;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b1;
        check("flush_frozen_valid", {63'd0, o1_valid}, 64'd0);
        send(1, 5'd10, 5'd5, 1'b1, 1'b1, 5'd14, 1'b1, 1'b0, 2'd0, 32'h0, 32'h5555, 32'h8001, 0);
        check("stall_after_flush", {62'd0, o1_stall}, 64'd1);

        // Flush wins over a simultaneous issue.
        in_rs = 5'd5; in_use_rs = 1'b1; in_wsel = 5'd1; in_valid = 1'b1; flush = 1'b1;
        #1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_issue_valid", {63'd0, o1_valid}, 64'd0);

        // Four more load-use pairs: five hazard cycles saturate a 2-bit counter at 3.
        for (int i = 0; i < 4; i++) begin
            send(1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 32'h8001, 0);
            send(1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h8001, 1);
        end
        check("stall_saturate", {62'd0, o1_stall}, 64'd3);
        check("sb_drained", 64'(sbq.size()), 64'd0);

        // Mid-operation reset, then the no-forwarding instances.
        sb_en = 1'b0;
        nRST = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, o1_valid}, 64'd0);
        check("rst_mid_stall", {62'd0, o1_stall}, 64'd0);
        nRST = 1'b1;
        for (int p = 0; p < 2; p++) begin
            send(0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 0);
            in_rs = 5'd4; in_use_rs = 1'b1; in_rt = 5'd0; in_use_rt = 1'b0;
            in_wsel = 5'd16; in_regwen = 1'b0; in_is_load = 1'b0; in_valid = 1'b1;
            #1;
            for (int i = 0; i < 3; i++) begin
                check("f0_stall_ready", {63'd0, o0_ready}, 64'd0);
                tick();
            end
            wb_wen = 1'b1; wb_wsel = 5'd4; wb_wdat = 32'h0000_4444 + 32'(p);
            #1;
            check("f0_issue_ready", {63'd0, o0_ready}, 64'd1);
            tick();
            wb_wen = 1'b0; in_valid = 1'b0;
            check("f0_valid", {63'd0, o0_valid}, 64'd1);
            check("f0_bypass", {32'd0, o0_r1}, 64'h4444 + 64'(p));
            check("f0_stall", {48'd0, o0_stall}, 64'(3 * (p + 1)));
            check("f0_stall_sat", {62'd0, o2_stall}, 64'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised decode/issue stage for the pipelined MIPS core. It sits between the fetch latch and execute and contains:

- an internal register file with write-through bypass,
- an immediate extender,
- a RAW-hazard scoreboard with a selectable forwarding mode,
- the decode→execute pipeline register, using a valid/ready handshake with flush.

It replaces the fixed-width, hazard-unaware decode latch by generating stall (backpressure) itself.

## Interface
Parameters:
- DATA_W, 32: register/data width; must be ≥ 32.
- NREGS, 32: register count; power of two; REG_W = log2(NREGS).
- DEPTH, 3: in-flight instructions tracked after decode (EX, MEM, WB-pending); ≥ 1.
- FORWARD, 1: 1 = full forwarding downstream, stall only on load-use; 0 = no forwarding, stall on any pending write.
- PAYLOAD_W, 16: opaque control-unit bits carried to execute.
- STALL_W, 16: stall-counter width.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents a decoded instruction.
- in_ready  out  1  decode accepts this cycle (combinational).
- in_rs, in_rt  in  REG_W each  source register selects.
- in_use_rs, in_use_rt  in  1 each  the corresponding source is actually read.
- in_wsel  in  REG_W  destination register.
- in_regwen  in  1  instruction writes in_wsel.
- in_is_load  in  1  instruction is a load.
- in_imm  in  16  raw immediate.
- in_imm_mode  in  2  0 zero-extend, 1 sign-extend, 2 upper (imm<<16), 3 reserved (treat as 0).
- in_payload  in  PAYLOAD_W  control bits.
- out_ready  in  1  execute can accept (low = freeze).
- flush  in  1  kill the instruction in the output register.
- wb_wen  in  1  writeback enable.
- wb_wsel  in  REG_W  writeback register.
- wb_wdat  in  DATA_W  writeback data.
- out_valid  out  1  output register holds a live instruction.
- out_rdat1, out_rdat2  out  DATA_W each  operands.
- out_imm  out  DATA_W  extended immediate.
- out_wsel  out  REG_W  destination register.
- out_regwen, out_is_load  out  1 each  registered copies of the inputs.
- out_payload  out  PAYLOAD_W  registered copy of the input.
- stall_cnt  out  STALL_W  hazard-stall cycles, saturating.

## Operation
Register file:
- NREGS×DATA_W array; writes occur at posedge when wb_wen is high and wb_wsel≠0.
- Register 0 always reads 0.
- Read bypass: if wb_wen && wb_wsel==sel && sel≠0, the read returns wb_wdat in the same cycle.

Scoreboard:
- DEPTH entries of {valid, wsel, regwen, is_load}.
- Entry 0 mirrors the output register. Entry k is the instruction k stages past decode.
- When out_ready is high, entries shift: k→k+1, the last entry retires, and entry 0 loads the issuing instruction or a bubble.

A source "matches" when its in_use bit is set, the register is nonzero, and it equals the wsel of a valid, regwen entry. hazard is defined per mode:
- FORWARD=1: a match against entry 0 with is_load=1.
- FORWARD=0: a match against any entry.

Issue and output register:
- issue = in_valid && out_ready && !hazard.
- in_ready = out_ready && !hazard.
- When out_ready is high the output register loads the instruction with out_valid=issue; otherwise it holds all fields.
- flush forces out_valid=0 and entry 0 valid=0 next cycle, overriding a load. Deeper entries are unaffected.
- stall_cnt increments each cycle in_valid && out_ready && hazard, and saturates at all-ones.

## Timing
- Reset: out_valid, out_regwen, out_is_load and every scoreboard entry = 0. All data outputs, out_wsel, out_payload and stall_cnt = 0. Register file is all 0. Reset mid-operation discards everything in flight.
- Latency: one cycle from an accepting edge to out_*.
- Operands are sampled at issue, including the wb bypass. The output register never re-reads operands while frozen.
- Simultaneous flush and issue: flush wins, and the issued instruction is lost. Fetch must replay it.
- Simultaneous flush and out_ready=0: out_valid clears anyway.
- Load-use with FORWARD=1 costs exactly one stall cycle, provided out_ready stays high.
- FORWARD=0 stalls until the producer retires from entry DEPTH-1. It can then issue in the same cycle the producer's writeback happens, because the bypass supplies the data.

## Test plan
- Reset, then write r5=0x1234 via wb. Issue with rs=5 and use_rs=1 → next cycle out_rdat1=0x1234 and out_valid=1.
- Same cycle: wb writes r7=0xCAFE while an instruction issues reading rt=7 → out_rdat2=0xCAFE. A write to r0 followed by a read of r0 → 0.
- FORWARD=1: a load to r3 issues, next instruction reads r3 → in_ready=0 for 1 cycle, stall_cnt=1, then the instruction issues. A non-load producer → no stall.
- FORWARD=0, DEPTH=3: an ALU op writes r4, the consumer reads r4 → 3 stall cycles (stall_cnt=3), issuing on the producer's retire cycle.
- out_ready=0 for 4 cycles with in_valid=1 → outputs frozen, in_ready=0, stall_cnt unchanged. Then assert flush → out_valid=0 and entry 0 cleared, so a subsequent dependent instruction does not stall.
- imm=0x8001: mode 0 → 0x00008001, mode 1 → 0xFFFF8001, mode 2 → 0x80010000. With STALL_W=2, 5 hazard cycles → stall_cnt=3.
